// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both ends of the link.
//   SPI_WIDTH      : bits per transferred word
//   SPI_DEFAULT_TX : byte sent when nothing has been queued. spi_master uses
//                    the same idle convention.
//   spi_state_e    : frame-level state of the peripheral endpoint
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam logic [SPI_WIDTH-1:0] SPI_DEFAULT_TX = 8'hFF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Pin and local-bus bundle for the SPI peripheral endpoint.
//   ss, sck, mosi, miso, miso_oe : SPI wires (miso_oe enables the miso driver)
//   data_in, load, tx_ready      : transmit buffer write port
//   data_out, new_data           : received byte and its one-cycle strobe
//   busy                         : a frame is in progress
// The slave modport is the endpoint's view. The master modport is the view
// of whatever drives the wires and the local bus.
interface spi_slave_if;
    import spi_pkg::*;

    logic                 ss;
    logic                 sck;
    logic                 mosi;
    logic                 miso;
    logic                 miso_oe;
    logic [SPI_WIDTH-1:0] data_in;
    logic                 load;
    logic                 tx_ready;
    logic [SPI_WIDTH-1:0] data_out;
    logic                 new_data;
    logic                 busy;

    modport slave (
        input  ss, sck, mosi, data_in, load,
        output miso, miso_oe, tx_ready, data_out, new_data, busy
    );

    modport master (
        output ss, sck, mosi, data_in, load,
        input  miso, miso_oe, tx_ready, data_out, new_data, busy
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by one extra
// flop that provides edge detection.
//   clk, rst : system clock and asynchronous active-low reset
//   din      : asynchronous input pin
//   level    : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
// RESET_VAL should be the idle level of the pin. That way, leaving reset
// does not produce a false edge.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= RESET_VAL;
                    else      sync_reg[gi] <= din;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= RESET_VAL;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_reg <= RESET_VAL;
        else      prev_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  =  level & ~prev_reg;
    assign fall  = ~level &  prev_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral endpoint, CPOL 0 / CPHA 1, oversampled on the local clock.
//   clk, rst : system clock and asynchronous active-low reset
//   bus      : spi_slave_if.slave
//              - SPI wires ss/sck/mosi in; miso/miso_oe out
//              - transmit buffer port data_in/load with tx_ready
//              - received byte data_out with new_data strobe
//              - busy
// On each synchronized sck rise, the next MSB is presented on miso. On each
// sck fall, mosi is shifted in. After every 8th fall, the received byte is
// published and the shifter reloads from the one-deep transmit buffer, or
// from DEFAULT_TX when the buffer is empty. This allows back-to-back bytes
// within one ss-low frame.
// SYNC_STAGES must be at least 2.
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [SPI_WIDTH-1:0] DEFAULT_TX  = SPI_DEFAULT_TX,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam int CNT_W = $clog2(SPI_WIDTH);

    // Synchronized inputs and their edges.
    logic ss_level, ss_rise, ss_fall;
    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_sync;

    // ss idles high, so its chain resets to 1. This keeps miso_oe low and
    // avoids a false ss_fall when leaving reset.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.ss),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // Only the edges of sck matter; its level is unused.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.sck),
        .level (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // mosi uses the same chain depth as sck, with no edge flop. It is
    // sampled on sck_fall, half a period after the master changed it.
    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) mosi_sync_reg[gi] <= 1'b0;
                    else      mosi_sync_reg[gi] <= bus.mosi;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) mosi_sync_reg[gi] <= 1'b0;
                    else      mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];

    // Frame state and datapath.
    spi_state_e           state_reg, state_next;
    logic [SPI_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic                 miso_reg, miso_next;
    logic [SPI_WIDTH-1:0] data_out_reg, data_out_next;
    logic                 new_data_reg, new_data_next;
    logic [SPI_WIDTH-1:0] tx_buf_reg, tx_buf_next;
    logic                 tx_full_reg, tx_full_next;

    logic                 reload;
    logic [SPI_WIDTH-1:0] reload_byte;
    logic [SPI_WIDTH-1:0] shifted;

    // A load in the same cycle as a reload bypasses the buffer. The freshest
    // byte always goes out.
    assign reload_byte = bus.load    ? bus.data_in :
                         tx_full_reg ? tx_buf_reg  : DEFAULT_TX;
    assign shifted     = {shift_reg[SPI_WIDTH-2:0], mosi_sync};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            miso_reg     <= 1'b0;
            data_out_reg <= '0;
            new_data_reg <= 1'b0;
            tx_buf_reg   <= '0;
            tx_full_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_cnt_reg  <= bit_cnt_next;
            miso_reg     <= miso_next;
            data_out_reg <= data_out_next;
            new_data_reg <= new_data_next;
            tx_buf_reg   <= tx_buf_next;
            tx_full_reg  <= tx_full_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        miso_next     = miso_reg;
        data_out_next = data_out_reg;
        new_data_next = 1'b0;
        tx_buf_next   = tx_buf_reg;
        tx_full_next  = tx_full_reg;
        reload        = 1'b0;

        // Buffer write. Last write wins when the buffer is already full.
        if (bus.load) begin
            tx_buf_next  = bus.data_in;
            tx_full_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (ss_fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    shift_next   = reload_byte;
                    reload       = 1'b1;
                end
            end
            SHIFT: begin
                // ss_rise wins over any coincident sck edge. A partial byte
                // is simply dropped.
                if (ss_rise) begin
                    state_next = IDLE;
                end else if (sck_rise) begin
                    miso_next = shift_reg[SPI_WIDTH-1];
                end else if (sck_fall) begin
                    shift_next   = shifted;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == CNT_W'(SPI_WIDTH - 1)) begin
                        data_out_next = shifted;
                        new_data_next = 1'b1;
                        shift_next    = reload_byte;
                        reload        = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Consuming the buffer empties it. This also covers a coincident
        // load, whose byte went straight into the shifter.
        if (reload) begin
            tx_full_next = 1'b0;
        end
    end

    assign bus.miso     = miso_reg;
    assign bus.miso_oe  = ~ss_level;
    assign bus.tx_ready = ~tx_full_reg;
    assign bus.data_out = data_out_reg;
    assign bus.new_data = new_data_reg;
    assign bus.busy     = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave. A behavioural SPI master drives the
// wires at clk/16. A byte-level reference model tracks the one-deep
// transmit buffer and the last received byte.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int H = 8;  // sck half period in clk cycles

    logic clk;
    logic rst;

    spi_slave_if bus();

    spi_slave #(.DEFAULT_TX(8'hFF), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // new_data observer: counts high cycles and records the byte shown.
    int         nd_count = 0;
    logic [7:0] nd_last  = 8'h00;

    always @(negedge clk) begin
        if (bus.new_data === 1'b1) begin
            nd_count = nd_count + 1;
            nd_last  = bus.data_out;
        end
    end

    // Reference model state.
    logic       m_full;
    logic [7:0] m_buf;
    logic [7:0] m_rx;
    logic [7:0] m_exp_tx;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // At a byte boundary, the next outgoing byte is the buffered one, or
    // 8'hFF if the buffer is empty. The buffer is consumed either way.
    task automatic m_reload();
        m_exp_tx = m_full ? m_buf : 8'hFF;
        m_full   = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.data_in = v;
        bus.load    = 1'b1;
        tick(1);
        bus.load = 1'b0;
        m_buf    = v;
        m_full   = 1'b1;
        check("tx_ready_after_load", 32'(bus.tx_ready), 32'd0);
    endtask

    task automatic frame_begin();
        bus.ss = 1'b0;
        m_reload();
        tick(H);
        check("busy_in_frame", 32'(bus.busy), 32'd1);
        check("miso_oe_in_frame", 32'(bus.miso_oe), 32'd1);
        check("tx_ready_at_ss_fall", 32'(bus.tx_ready), 32'd1);
    endtask

    task automatic frame_end();
        bus.ss = 1'b1;
        tick(H);
        check("busy_after_frame", 32'(bus.busy), 32'd0);
        check("miso_oe_after_frame", 32'(bus.miso_oe), 32'd0);
    endtask

    // Shift nbits bits of mo. Optionally issue a load during bit 3 (ml_*),
    // or a load timed to coincide with the byte-end reload (col_*).
    task automatic frame_byte(input logic [7:0] mo, input int nbits,
                              input bit ml_en, input logic [7:0] ml_val,
                              input bit col_en, input logic [7:0] col_val);
        logic [7:0] mi;
        int         nd0;
        mi  = 8'h00;
        nd0 = nd_count;
        for (int i = 0; i < nbits; i++) begin
            bus.sck  = 1'b1;
            bus.mosi = mo[7-i];
            if (ml_en && i == 3) begin
                tick(1);
                bus.data_in = ml_val;
                bus.load    = 1'b1;
                tick(1);
                bus.load = 1'b0;
                m_buf    = ml_val;
                m_full   = 1'b1;
                tick(H - 2);
            end else begin
                tick(H);
            end
            mi[7-i] = bus.miso;
            bus.sck = 1'b0;
            if (col_en && i == 7) begin
                // The fall reaches the state logic SYNC_STAGES+1 edges later.
                tick(2);
                bus.data_in = col_val;
                bus.load    = 1'b1;
                tick(1);
                bus.load = 1'b0;
                check("collide_new_data", 32'(bus.new_data), 32'd1);
                check("collide_tx_ready", 32'(bus.tx_ready), 32'd1);
                tick(H - 3);
            end else begin
                tick(H);
            end
        end
        if (nbits == 8) begin
            check("miso_byte", 32'(mi), 32'(m_exp_tx));
            check("new_data_pulses", 32'(nd_count - nd0), 32'd1);
            check("data_out", 32'(bus.data_out), 32'(mo));
            check("new_data_value", 32'(nd_last), 32'(mo));
            $display("byte: mosi=%02h miso=%02h data_out=%02h", mo, mi, bus.data_out);
            m_rx = mo;
            if (col_en) begin
                m_exp_tx = col_val;
                m_full   = 1'b0;
            end else begin
                m_reload();
            end
        end else begin
            check("partial_no_new_data", 32'(nd_count - nd0), 32'd0);
            check("partial_data_out", 32'(bus.data_out), 32'(m_rx));
            $display("partial: %0d bits of %02h, data_out=%02h", nbits, mo, bus.data_out);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},     32'(bus.miso),     32'd0);
        check({tag, "_miso_oe"},  32'(bus.miso_oe),  32'd0);
        check({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
        check({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
        check({tag, "_new_data"}, 32'(bus.new_data), 32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
    endtask

    initial begin
        logic [7:0] rv;
        int         nb;
        int         nbits;
        bit         ml;

        bus.ss      = 1'b1;
        bus.sck     = 1'b0;
        bus.mosi    = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 8'h00;
        m_full      = 1'b0;
        m_buf       = 8'h00;
        m_rx        = 8'h00;
        m_exp_tx    = 8'hFF;

        rst = 1'b0;
        tick(3);
        check_reset_values("reset");
        rst = 1'b1;
        tick(4);

        // Basic byte.
        do_load(8'hA5);
        frame_begin();
        frame_byte(8'h3C, 8, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();

        // Empty buffer.
        frame_begin();
        frame_byte(8'h00, 8, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();

        // Multi-byte frame with a load during byte 1.
        do_load(8'h9A);
        frame_begin();
        frame_byte(8'h12, 8, 1'b1, 8'h56, 1'b0, 8'h00);
        frame_byte(8'h34, 8, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();

        // Abort after 5 bits, then a full frame.
        frame_begin();
        frame_byte(8'h5A, 5, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();
        frame_begin();
        frame_byte(8'hC3, 8, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();

        // Load colliding with the byte-end reload.
        frame_begin();
        frame_byte(8'h11, 8, 1'b0, 8'h00, 1'b1, 8'h77);
        frame_byte(8'h22, 8, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();

        // Asynchronous reset in the middle of a byte.
        frame_begin();
        do_load(8'hE7);
        frame_byte(8'h99, 3, 1'b0, 8'h00, 1'b0, 8'h00);
        #3 rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        m_full  = 1'b0;
        m_rx    = 8'h00;
        bus.ss  = 1'b1;
        bus.sck = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(4);
        frame_begin();
        frame_byte(8'h81, 8, 1'b0, 8'h00, 1'b0, 8'h00);
        frame_end();

        // Randomized frames.
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_load(8'($urandom));
            end
            frame_begin();
            nb = int'($urandom_range(3, 1));
            for (int b = 0; b < nb; b++) begin
                rv    = 8'($urandom);
                ml    = ($urandom_range(2, 0) == 0);
                nbits = 8;
                if (b == nb - 1 && $urandom_range(3, 0) == 0) begin
                    nbits = int'($urandom_range(7, 1));
                end
                frame_byte(rv, nbits, ml, 8'($urandom), 1'b0, 8'h00);
            end
            frame_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
